// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared word, fetch-state and fetch-entry types for the fetch front end
package if_fetch_unit_pkg;
    typedef logic [15:0] lc3b_word;
    typedef enum logic [1:0] {IDLE, REQ, DISCARD} lc3b_fetch_state;
    typedef struct packed {
        lc3b_word pc;
        lc3b_word ir;
    } lc3b_fetch_entry;
endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// fetch_fifo: registered FIFO of fetched {pc, ir} entries; flush beats push
module fetch_fifo
    import if_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  lc3b_fetch_entry din,
    output lc3b_fetch_entry head,
    output logic [CW-1:0]   count
);
    lc3b_fetch_entry mem_q [DEPTH];
    logic [AW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q;
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop) head_q <= head_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end
    // storage needs no reset; the consumer only looks at it when count is nonzero
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) mem_q[tail_q] <= din;
    end
    assign head  = mem_q[head_q];
    assign count = count_q;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: fetch PC, imem request FSM and buffered hand-off of words to decode
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_read,
    output logic [15:0] imem_address,
    input  logic [15:0] imem_rdata,
    input  logic        imem_resp,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [15:0] ir_out,
    output logic [15:0] pc_out,
    input  logic        redirect,
    input  logic [15:0] redirect_pc
);
    localparam int CW = $clog2(DEPTH) + 1;
    lc3b_fetch_state state_q, state_d;
    lc3b_word        fetch_pc_q, fetch_pc_d, discard_q, discard_d;
    lc3b_fetch_entry head, push_entry;
    logic [CW-1:0]   count, count_after;
    logic            push, pop;
    assign ir_valid     = count != '0;
    assign pop          = ir_valid && ir_ready && !redirect;
    assign push         = state_q == REQ && imem_resp && !redirect;
    assign count_after  = count + CW'(1) - CW'(pop);
    assign push_entry   = '{pc: fetch_pc_q, ir: imem_rdata};
    assign ir_out       = ir_valid ? head.ir : '0;
    assign pc_out       = ir_valid ? head.pc : '0;
    assign imem_read    = state_q != IDLE;
    assign imem_address = state_q == DISCARD ? discard_q : fetch_pc_q;
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (push_entry),
        .head  (head),
        .count (count)
    );
    // next state, fetch PC and the address of a read that must be drained after a redirect
    always_comb begin
        state_d    = state_q;
        discard_d  = discard_q;
        fetch_pc_d = redirect ? (redirect_pc & 16'hFFFE) : push ? fetch_pc_q + 16'd2 : fetch_pc_q;
        case (state_q)
            IDLE:    if (!redirect && count < CW'(DEPTH)) state_d = REQ;
            REQ: begin
                if (redirect) begin
                    state_d   = imem_resp ? IDLE : DISCARD;
                    discard_d = fetch_pc_q;
                end else if (imem_resp) begin
                    state_d = count_after < CW'(DEPTH) ? REQ : IDLE;
                end
            end
            DISCARD: if (imem_resp) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed vector table plus hand-written redirect/backpressure/reset sequences
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_read;
    logic [15:0] imem_address;
    logic [15:0] imem_rdata = '0;
    logic        imem_resp = 1'b0;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic [15:0] ir_out, pc_out;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    int n_cmp = 0;
    int n_fail = 0;

    if_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .ir_valid     (ir_valid),
        .ir_ready     (ir_ready),
        .ir_out       (ir_out),
        .pc_out       (pc_out),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, resp;
        logic [15:0] rdata;
        logic        rdy, redir;
        logic [15:0] rpc;
        logic        chk, chkd;
        logic        erd;
        logic [15:0] ea;
        logic        ev;
        logic [15:0] eo, ep;
    } vec_t;
    vec_t vec [13];

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_read(input logic [15:0] a);
        int k = 0;
        while (!imem_read && k < 20) begin
            tick();
            k++;
        end
        chk("read_seen", {15'b0, imem_read}, 16'd1);
        chk("req_addr", imem_address, a);
    endtask

    task automatic serve(input logic [15:0] a, input int dly);
        wait_read(a);
        repeat (dly) begin
            tick();
            chk("addr_stable", imem_address, a);
        end
        imem_resp  = 1'b1;
        imem_rdata = mdata(a);
        tick();
        imem_resp  = 1'b0;
    endtask

    initial begin
        //         rst resp rdata     rdy redir rpc  chk chkd erd ea        ev eo        ep
        vec[0]  = '{1, 0, 16'h0000, 0, 0, 16'h0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000};
        vec[1]  = '{1, 0, 16'h0000, 0, 0, 16'h0, 1, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000};
        vec[2]  = '{0, 0, 16'h0000, 1, 0, 16'h0, 1, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000};
        vec[3]  = '{0, 0, 16'h0000, 1, 0, 16'h0, 1, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000};
        vec[4]  = '{0, 1, 16'h8000, 1, 0, 16'h0, 1, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000};
        vec[5]  = '{0, 0, 16'h0000, 1, 0, 16'h0, 1, 1, 1, 16'h0002, 1, 16'h8000, 16'h0000};
        vec[6]  = '{0, 1, 16'h8002, 1, 0, 16'h0, 1, 0, 1, 16'h0002, 0, 16'h0000, 16'h0000};
        vec[7]  = '{0, 0, 16'h0000, 1, 0, 16'h0, 1, 1, 1, 16'h0004, 1, 16'h8002, 16'h0002};
        vec[8]  = '{0, 1, 16'h8004, 1, 0, 16'h0, 1, 0, 1, 16'h0004, 0, 16'h0000, 16'h0000};
        vec[9]  = '{0, 1, 16'h8006, 1, 0, 16'h0, 1, 1, 1, 16'h0006, 1, 16'h8004, 16'h0004};
        vec[10] = '{0, 0, 16'h0000, 0, 0, 16'h0, 1, 1, 1, 16'h0008, 1, 16'h8006, 16'h0006};
        vec[11] = '{0, 1, 16'h8008, 0, 0, 16'h0, 1, 1, 1, 16'h0008, 1, 16'h8006, 16'h0006};
        vec[12] = '{0, 0, 16'h0000, 0, 0, 16'h0, 1, 1, 0, 16'h0000, 1, 16'h8006, 16'h0006};
        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            if (vec[i].chk) begin
                chk($sformatf("v%0d_read", i), {15'b0, imem_read}, {15'b0, vec[i].erd});
                if (vec[i].erd) chk($sformatf("v%0d_addr", i), imem_address, vec[i].ea);
                chk($sformatf("v%0d_valid", i), {15'b0, ir_valid}, {15'b0, vec[i].ev});
                if (vec[i].chkd) begin
                    chk($sformatf("v%0d_ir", i), ir_out, vec[i].eo);
                    chk($sformatf("v%0d_pc", i), pc_out, vec[i].ep);
                end
            end
            reset       = vec[i].rst;
            imem_resp   = vec[i].resp;
            imem_rdata  = vec[i].rdata;
            ir_ready    = vec[i].rdy;
            redirect    = vec[i].redir;
            redirect_pc = vec[i].rpc;
            tick();
        end
        imem_resp = 1'b0;

        // backpressure: FIFO fills, fetch stops, head holds
        reset = 1'b1; ir_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        serve(16'h0000, 0);
        serve(16'h0002, 0);
        chk("full_read", {15'b0, imem_read}, 16'd0);
        chk("full_ir", ir_out, mdata(16'h0000));
        tick();
        chk("hold_read", {15'b0, imem_read}, 16'd0);
        chk("hold_ir", ir_out, mdata(16'h0000));
        chk("hold_pc", pc_out, 16'h0000);
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        chk("pop_pc", pc_out, 16'h0002);
        chk("pop_ir", ir_out, mdata(16'h0002));
        serve(16'h0004, 0);

        // redirect while a read is outstanding
        reset = 1'b1; ir_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        serve(16'h0000, 1);
        serve(16'h0002, 0);
        serve(16'h0004, 0);
        wait_read(16'h0006);
        redirect = 1'b1; redirect_pc = 16'h3001;
        tick();
        redirect = 1'b0;
        chk("disc_read", {15'b0, imem_read}, 16'd1);
        chk("disc_addr", imem_address, 16'h0006);
        chk("disc_valid", {15'b0, ir_valid}, 16'd0);
        tick();
        chk("disc_addr2", imem_address, 16'h0006);
        imem_resp = 1'b1; imem_rdata = 16'hDEAD;
        tick();
        imem_resp = 1'b0;
        chk("disc_drop_valid", {15'b0, ir_valid}, 16'd0);
        wait_read(16'h3000);
        chk("pre_resp_valid", {15'b0, ir_valid}, 16'd0);
        imem_resp = 1'b1; imem_rdata = mdata(16'h3000);
        tick();
        imem_resp = 1'b0;
        chk("rd_valid", {15'b0, ir_valid}, 16'd1);
        chk("rd_ir", ir_out, mdata(16'h3000));
        chk("rd_pc", pc_out, 16'h3000);

        // redirect together with resp, then two redirects while draining
        imem_resp = 1'b1; imem_rdata = 16'hBAD1; redirect = 1'b1; redirect_pc = 16'h4000;
        tick();
        imem_resp = 1'b0; redirect = 1'b0;
        chk("same_read", {15'b0, imem_read}, 16'd0);
        chk("same_valid", {15'b0, ir_valid}, 16'd0);
        wait_read(16'h4000);
        redirect = 1'b1; redirect_pc = 16'h5000;
        tick();
        redirect_pc = 16'h6002;
        tick();
        redirect = 1'b0;
        chk("dd_addr", imem_address, 16'h4000);
        chk("dd_valid", {15'b0, ir_valid}, 16'd0);
        imem_resp = 1'b1; imem_rdata = 16'hBAD2;
        tick();
        imem_resp = 1'b0;
        chk("dd_drop_valid", {15'b0, ir_valid}, 16'd0);
        serve(16'h6002, 0);
        chk("dd_ir", ir_out, mdata(16'h6002));
        chk("dd_pc", pc_out, 16'h6002);

        // wrap from FFFE to 0000, with bit 0 of redirect_pc ignored
        reset = 1'b1; ir_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        tick();
        redirect = 1'b0;
        serve(16'hFFFE, 0);
        chk("wrap_pc0", pc_out, 16'hFFFE);
        chk("wrap_ir0", ir_out, mdata(16'hFFFE));
        serve(16'h0000, 0);
        ir_ready = 1'b1;
        tick();
        chk("wrap_pc1", pc_out, 16'h0000);
        chk("wrap_ir1", ir_out, mdata(16'h0000));

        // reset in the middle of a request
        wait_read(16'h0002);
        reset = 1'b1;
        tick();
        chk("rst_read", {15'b0, imem_read}, 16'd0);
        chk("rst_valid", {15'b0, ir_valid}, 16'd0);
        reset = 1'b0;
        wait_read(16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
